bus_transfer_arbiter: RTL

BUS_TRANSFER_ARBITER -- requirements
Module: bus_transfer_arbiter

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_transfer_arbiter_rr_select.sv | 31 +++
 rtl/bus_transfer_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus transfer arbiter: FSM state encoding,
// bus width and a saturating increment used by the optional transfer counter.
package bus_pkg;
  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [BUS_W-1:0] sat_inc(input logic [BUS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/bus_transfer_arbiter_rr_select.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NUM_REQ. Returns a one-hot grant and its index.
module rr_select
  import bus_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);
  logic          found;
  logic [PW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = PW'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end
endmodule

// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter moving one register onto another over a shared bus.
// Optional `BUS_ARBITER_CNT_EN adds a saturating completed-transfer counter.
module bus_transfer_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int NUM_REQ  = 4
) (
  input  logic                              bus_arbiter_clock,
  input  logic                              bus_arbiter_reset_n,
  input  logic [NUM_REQ-1:0]                bus_arbiter_req,
  input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0] bus_arbiter_req_src,
  input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0] bus_arbiter_req_dst,
  output logic [NUM_REQ-1:0]                bus_arbiter_done,
  output logic [NUM_REQ-1:0]                bus_arbiter_err,
  output logic [NUM_REGS-1:0]               bus_register_out_en,
  output logic [NUM_REGS-1:0]               bus_register_input_en,
  output logic                              bus_arbiter_busy
`ifdef BUS_ARBITER_CNT_EN
  ,output logic [BUS_W-1:0]                 bus_arbiter_xfer_count
`endif
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d, win_q, win_d, gidx;
  logic [IW-1:0]        src_q, src_d, dst_q, dst_d, src_sel, dst_sel;
  logic                 ill_q, ill_d, sel_ill;
  logic [NUM_REQ-1:0]   gnt;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (bus_arbiter_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign src_sel = bus_arbiter_req_src[gidx*IW +: IW];
  assign dst_sel = bus_arbiter_req_dst[gidx*IW +: IW];
  // Illegal requests skip the bus phases entirely and report err from DONE.
  assign sel_ill = (src_sel == dst_sel)
                || ({1'b0, src_sel} >= (IW+1)'(NUM_REGS))
                || ({1'b0, dst_sel} >= (IW+1)'(NUM_REGS));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: if (|gnt) begin
        win_d   = gidx;
        src_d   = src_sel;
        dst_d   = dst_sel;
        ill_d   = sel_ill;
        state_d = sel_ill ? ST_DONE : ST_DRIVE;
      end
      ST_DRIVE: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_DONE;
      ST_DONE: begin
        ptr_d   = (win_q == PW'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_register_out_en   = '0;
    bus_register_input_en = '0;
    bus_arbiter_done      = '0;
    bus_arbiter_err       = '0;
    bus_arbiter_busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_DRIVE: bus_register_out_en[src_q] = 1'b1;
      ST_LATCH: begin
        bus_register_out_en[src_q]   = 1'b1;
        bus_register_input_en[dst_q] = 1'b1;
      end
      ST_DONE: begin
        if (ill_q) bus_arbiter_err[win_q]  = 1'b1;
        else       bus_arbiter_done[win_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge bus_arbiter_clock) begin
    if (!bus_arbiter_reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ill_q   <= ill_d;
    end
  end

`ifdef BUS_ARBITER_CNT_EN
  logic [BUS_W-1:0] cnt_q;

  always_ff @(posedge bus_arbiter_clock) begin
    if (!bus_arbiter_reset_n)                 cnt_q <= '0;
    else if (state_q == ST_DONE && !ill_q)    cnt_q <= sat_inc(cnt_q);
  end

  assign bus_arbiter_xfer_count = cnt_q;
`endif
endmodule
